// File: rtl/pi_ctl_gen.sv
// Parametrised priority-interrupt controller: request collection, hold arbitration, PI-cycle handshake.
// Optional diagnostic state read-back port is built when PI_DIAG_READ_EN is defined.
module pi_ctl_gen #(
  parameter  int NLEVELS     = 7,
  parameter  int SYNC_STAGES = 2,
  localparam int LW          = $clog2(NLEVELS + 1)
) (
  input  logic               clk_pi_h,
  input  logic               mr_reset_h,
  input  logic [NLEVELS-1:0] ebus_pi_e_h,
  input  logic               cono_pi_h,
  input  logic [NLEVELS+6:0] cono_data_h,
  input  logic               con_pi_disable_h,
  input  logic               con_pi_cycle_h,
  input  logic               con_set_pih_h,
  input  logic               con_pi_dismiss_h,
  output logic               pi_req_h,
  output logic [LW-1:0]      pi_level_h,
  output logic [NLEVELS-1:0] pi_hold_h,
  output logic [LW-1:0]      pi_hold_lvl_h,
  output logic [NLEVELS-1:0] pi_act_h,
  output logic [NLEVELS-1:0] pi_pir_h,
`ifdef PI_DIAG_READ_EN
  input  logic               diag_read_pi_h,
  output logic [3*NLEVELS:0] pi_diag_d_h,
`endif
  output logic               pi_on_h
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CYCLE} state_t;

  state_t             r_state;
  logic               r_req;
  logic [LW-1:0]      r_lvl;
  logic               r_on;
  logic [NLEVELS-1:0] r_act;
  logic [NLEVELS-1:0] r_pir;
  logic [NLEVELS-1:0] r_hold;

  logic [NLEVELS-1:0] w_dreq;
  logic [NLEVELS-1:0] w_pend;
  logic [NLEVELS-1:0] w_elig;
  logic [LW-1:0]      w_hold_lvl;
  logic [LW-1:0]      w_cand;
  logic [NLEVELS-1:0] w_mask;
  logic               w_clr, w_drop, w_setp, w_lvon, w_lvoff, w_soff, w_son;
  logic               w_set_pih;
  logic [NLEVELS-1:0] w_set_vec;
  logic [NLEVELS-1:0] w_dis_vec;

  // Device request synchroniser; zero stages is a straight wire
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_dreq = ebus_pi_e_h;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][NLEVELS-1:0] r_sync;
      always_ff @(posedge clk_pi_h) begin
        if (mr_reset_h) begin
          r_sync <= '0;
        end else begin
          r_sync[0] <= ebus_pi_e_h;
          for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
      end
      assign w_dreq = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  assign w_pend = {NLEVELS{r_on}} & r_act & (w_dreq | r_pir);

  always_comb begin
    w_hold_lvl = '0;
    for (int i = NLEVELS - 1; i >= 0; i--)
      if (r_hold[i]) w_hold_lvl = LW'(i + 1);
  end

  // Only levels strictly above the current hold in priority may interrupt
  always_comb begin
    w_elig = '0;
    w_cand = '0;
    for (int i = 0; i < NLEVELS; i++)
      w_elig[i] = w_pend[i] & ((w_hold_lvl == '0) | (LW'(i + 1) < w_hold_lvl));
    for (int i = NLEVELS - 1; i >= 0; i--)
      if (w_elig[i]) w_cand = LW'(i + 1);
  end

  assign w_mask  = cono_data_h[NLEVELS-1:0];
  assign w_clr   = cono_pi_h & cono_data_h[NLEVELS];
  assign w_drop  = cono_pi_h & cono_data_h[NLEVELS+1];
  assign w_setp  = cono_pi_h & cono_data_h[NLEVELS+2];
  assign w_lvon  = cono_pi_h & cono_data_h[NLEVELS+3];
  assign w_lvoff = cono_pi_h & cono_data_h[NLEVELS+4];
  assign w_soff  = cono_pi_h & cono_data_h[NLEVELS+5];
  assign w_son   = cono_pi_h & cono_data_h[NLEVELS+6];

  // Later ops override earlier ones: drop before set, off before on
  always_ff @(posedge clk_pi_h) begin
    if (mr_reset_h || w_clr) begin
      r_on  <= 1'b0;
      r_act <= '0;
      r_pir <= '0;
    end else if (cono_pi_h) begin
      r_pir <= (r_pir & ~(w_drop ? w_mask : '0)) | (w_setp ? w_mask : '0);
      r_act <= (r_act & ~(w_lvoff ? w_mask : '0)) | (w_lvon ? w_mask : '0);
      if (w_son)       r_on <= 1'b1;
      else if (w_soff) r_on <= 1'b0;
    end
  end

  assign w_set_pih = (r_state == S_CYCLE) & con_set_pih_h;

  always_comb begin
    w_set_vec = '0;
    for (int i = 0; i < NLEVELS; i++)
      w_set_vec[i] = w_set_pih & (r_lvl == LW'(i + 1));
  end

  // Dismiss isolates the lowest set bit of the pre-set hold vector
  assign w_dis_vec = con_pi_dismiss_h ? (r_hold & (~r_hold + NLEVELS'(1))) : '0;

  always_ff @(posedge clk_pi_h) begin
    if (mr_reset_h || w_clr) r_hold <= '0;
    else                     r_hold <= (r_hold & ~w_dis_vec) | w_set_vec;
  end

  always_ff @(posedge clk_pi_h) begin
    if (mr_reset_h) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_lvl   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cand != '0 && !con_pi_disable_h) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_lvl   <= w_cand;
          end
        end
        S_REQ: begin
          if (con_pi_cycle_h) begin
            r_state <= S_CYCLE;
            r_req   <= 1'b0;
          end else if (con_pi_disable_h || w_cand == '0) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_lvl   <= '0;
          end else begin
            r_lvl   <= w_cand;
          end
        end
        S_CYCLE: begin
          if (con_set_pih_h || !con_pi_cycle_h) begin
            r_state <= S_IDLE;
            r_lvl   <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_lvl   <= '0;
        end
      endcase
    end
  end

`ifdef PI_DIAG_READ_EN
  logic [3*NLEVELS:0] r_diag;
  always_ff @(posedge clk_pi_h) begin
    if (mr_reset_h)          r_diag <= '0;
    else if (diag_read_pi_h) r_diag <= {r_on, r_act, r_pir, r_hold};
    else                     r_diag <= '0;
  end
  assign pi_diag_d_h = r_diag;
`endif

  assign pi_req_h      = r_req;
  assign pi_level_h    = r_lvl;
  assign pi_hold_h     = r_hold;
  assign pi_hold_lvl_h = w_hold_lvl;
  assign pi_act_h      = r_act;
  assign pi_pir_h      = r_pir;
  assign pi_on_h       = r_on;

endmodule

// File: tb/tb_pi_ctl_gen.sv
// Bench for pi_ctl_gen: CONO op table, directed PI-cycle sequences, randomized run against a reference model.
module tb_pi_ctl_gen;
  localparam int N    = 7;
  localparam int SYNC = 2;
  localparam int LW   = 3;

  localparam logic [13:0] OP_CLR   = 14'(1) << 7;
  localparam logic [13:0] OP_DROP  = 14'(1) << 8;
  localparam logic [13:0] OP_SETP  = 14'(1) << 9;
  localparam logic [13:0] OP_LVON  = 14'(1) << 10;
  localparam logic [13:0] OP_LVOFF = 14'(1) << 11;
  localparam logic [13:0] OP_SOFF  = 14'(1) << 12;
  localparam logic [13:0] OP_SON   = 14'(1) << 13;

  logic          clk_pi_h = 1'b0;
  logic          mr_reset_h;
  logic [N-1:0]  ebus_pi_e_h;
  logic          cono_pi_h;
  logic [N+6:0]  cono_data_h;
  logic          con_pi_disable_h, con_pi_cycle_h, con_set_pih_h, con_pi_dismiss_h;
  logic          pi_req_h;
  logic [LW-1:0] pi_level_h, pi_hold_lvl_h;
  logic [N-1:0]  pi_hold_h, pi_act_h, pi_pir_h;
  logic          pi_on_h;
`ifdef PI_DIAG_READ_EN
  logic          diag_read_pi_h;
  logic [3*N:0]  pi_diag_d_h;
`endif

  int n_chk = 0;
  int n_err = 0;

  pi_ctl_gen #(.NLEVELS(N), .SYNC_STAGES(SYNC)) dut (
    .clk_pi_h(clk_pi_h), .mr_reset_h(mr_reset_h), .ebus_pi_e_h(ebus_pi_e_h),
    .cono_pi_h(cono_pi_h), .cono_data_h(cono_data_h),
    .con_pi_disable_h(con_pi_disable_h), .con_pi_cycle_h(con_pi_cycle_h),
    .con_set_pih_h(con_set_pih_h), .con_pi_dismiss_h(con_pi_dismiss_h),
    .pi_req_h(pi_req_h), .pi_level_h(pi_level_h), .pi_hold_h(pi_hold_h),
    .pi_hold_lvl_h(pi_hold_lvl_h), .pi_act_h(pi_act_h), .pi_pir_h(pi_pir_h),
`ifdef PI_DIAG_READ_EN
    .diag_read_pi_h(diag_read_pi_h), .pi_diag_d_h(pi_diag_d_h),
`endif
    .pi_on_h(pi_on_h)
  );

  always #5 clk_pi_h = ~clk_pi_h;

  task automatic tick();
    @(posedge clk_pi_h);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic cono(input logic [13:0] w);
    cono_pi_h = 1'b1; cono_data_h = w;
    tick();
    cono_pi_h = 1'b0; cono_data_h = '0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  function automatic logic [31:0] dut_outs();
    return {3'b0, pi_req_h, pi_level_h, pi_hold_h, pi_hold_lvl_h, pi_act_h, pi_pir_h, pi_on_h};
  endfunction

  // ---------------- reference model ----------------
  bit           m_on;
  logic [N-1:0] m_act, m_pir, m_hold;
  logic [N-1:0] m_sh [SYNC];
  int           m_ph;   // 0 idle, 1 requesting, 2 in PI cycle
  int           m_lvl;

  function automatic int top_level(input logic [N-1:0] v);
    for (int l = 1; l <= N; l++) if (v[l-1]) return l;
    return 0;
  endfunction

  task automatic model_step();
    logic [N-1:0] dreq, m;
    int hl, cand, set_l;
    if (mr_reset_h) begin
      m_on = 0; m_act = '0; m_pir = '0; m_hold = '0;
      for (int s = 0; s < SYNC; s++) m_sh[s] = '0;
      m_ph = 0; m_lvl = 0;
      return;
    end
    dreq = m_sh[SYNC-1];
    hl   = top_level(m_hold);
    cand = 0;
    for (int l = N; l >= 1; l--)
      if (m_on && m_act[l-1] && (dreq[l-1] || m_pir[l-1]) && (hl == 0 || l < hl)) cand = l;
    set_l = 0;
    if (m_ph == 0) begin
      if (cand != 0 && !con_pi_disable_h) begin m_ph = 1; m_lvl = cand; end
    end else if (m_ph == 1) begin
      if (con_pi_cycle_h) m_ph = 2;
      else if (con_pi_disable_h || cand == 0) begin m_ph = 0; m_lvl = 0; end
      else m_lvl = cand;
    end else begin
      if (con_set_pih_h) begin set_l = m_lvl; m_ph = 0; m_lvl = 0; end
      else if (!con_pi_cycle_h) begin m_ph = 0; m_lvl = 0; end
    end
    if (con_pi_dismiss_h && hl != 0) m_hold[hl-1] = 1'b0;
    if (set_l != 0) m_hold[set_l-1] = 1'b1;
    m = cono_data_h[N-1:0];
    if (cono_pi_h) begin
      if (cono_data_h[7]) begin
        m_on = 0; m_act = '0; m_pir = '0; m_hold = '0;
      end else begin
        if (cono_data_h[8])  m_pir = m_pir & ~m;
        if (cono_data_h[9])  m_pir = m_pir | m;
        if (cono_data_h[11]) m_act = m_act & ~m;
        if (cono_data_h[10]) m_act = m_act | m;
        if (cono_data_h[12]) m_on = 0;
        if (cono_data_h[13]) m_on = 1;
      end
    end
    for (int s = SYNC - 1; s > 0; s--) m_sh[s] = m_sh[s-1];
    m_sh[0] = ebus_pi_e_h;
  endtask

  function automatic logic [31:0] model_outs();
    logic [LW-1:0] lv;
    lv = (m_ph == 0) ? '0 : LW'(m_lvl);
    return {3'b0, (m_ph == 1), lv, m_hold, LW'(top_level(m_hold)), m_act, m_pir, m_on};
  endfunction

  // ---------------- CONO op table ----------------
  typedef struct {
    logic [13:0]  setup;
    logic [13:0]  op;
    logic         exp_on;
    logic [N-1:0] exp_act;
    logic [N-1:0] exp_pir;
  } cono_vec_t;

  cono_vec_t tbl [9];

  initial begin
    tbl[0] = '{OP_SON | OP_LVON | 14'h7F,           OP_SETP | 14'h10,              1'b1, 7'h7F, 7'h10};
    tbl[1] = '{OP_SON | OP_LVON | 14'h7F,           OP_LVOFF | OP_LVON | 14'h0F,   1'b1, 7'h7F, 7'h00};
    tbl[2] = '{OP_SON | OP_LVON | 14'h7F,           OP_LVOFF | 14'h05,             1'b1, 7'h7A, 7'h00};
    tbl[3] = '{OP_SETP | 14'h33,                    OP_DROP | OP_SETP | 14'h03,    1'b0, 7'h00, 7'h33};
    tbl[4] = '{OP_SETP | 14'h33,                    OP_DROP | 14'h21,              1'b0, 7'h00, 7'h12};
    tbl[5] = '{OP_SON | OP_LVON | 14'h7F,           OP_SOFF | OP_SON,              1'b1, 7'h7F, 7'h00};
    tbl[6] = '{OP_SON,                              OP_SOFF,                       1'b0, 7'h00, 7'h00};
    tbl[7] = '{OP_SON | OP_LVON | OP_SETP | 14'h7F, OP_CLR | OP_SETP | OP_SON | OP_LVON | 14'h7F, 1'b0, 7'h00, 7'h00};
    tbl[8] = '{14'h0,                               OP_CLR | OP_SETP | 14'h10,     1'b0, 7'h00, 7'h00};

    mr_reset_h = 1'b1; ebus_pi_e_h = '0; cono_pi_h = 1'b0; cono_data_h = '0;
    con_pi_disable_h = 1'b0; con_pi_cycle_h = 1'b0; con_set_pih_h = 1'b0; con_pi_dismiss_h = 1'b0;
`ifdef PI_DIAG_READ_EN
    diag_read_pi_h = 1'b0;
`endif
    ticks(2);
    chk("reset_state", dut_outs(), 32'h0);
    mr_reset_h = 1'b0;

    foreach (tbl[i]) begin
      mr_reset_h = 1'b1; tick(); mr_reset_h = 1'b0;
      if (tbl[i].setup != '0) cono(tbl[i].setup);
      cono(tbl[i].op);
      chk($sformatf("cono_tbl%0d", i), {17'b0, pi_on_h, pi_act_h, pi_pir_h},
          {17'b0, tbl[i].exp_on, tbl[i].exp_act, tbl[i].exp_pir});
    end

    // Seq A: level 3 request latency, cycle and hold commit
    mr_reset_h = 1'b1; tick(); mr_reset_h = 1'b0;
    cono(OP_SON | OP_LVON | 14'h7F);
    ebus_pi_e_h = 7'h04;
    tick(); chk("lat_c1_req", 32'(pi_req_h), 32'd0);
    tick(); chk("lat_c2_req", 32'(pi_req_h), 32'd0);
    tick(); chk("lat_c3_req_lvl", {pi_req_h, pi_level_h}, {1'b1, 3'd3});
    con_pi_cycle_h = 1'b1; tick();
    chk("cycle_lvl3", {pi_req_h, pi_level_h}, {1'b0, 3'd3});
    con_set_pih_h = 1'b1; tick(); con_set_pih_h = 1'b0; con_pi_cycle_h = 1'b0;
    chk("setpih_lvl3", {pi_req_h, pi_level_h, pi_hold_h, pi_hold_lvl_h}, {1'b0, 3'd0, 7'h04, 3'd3});

    // Seq B: lower level blocked by hold, higher level gets through, dismiss order
    ebus_pi_e_h = 7'h14; ticks(4);
    chk("blocked_lvl5", 32'(pi_req_h), 32'd0);
    ebus_pi_e_h = 7'h16; ticks(3);
    chk("preempt_lvl2", {pi_req_h, pi_level_h}, {1'b1, 3'd2});
    con_pi_cycle_h = 1'b1; tick();
    con_set_pih_h = 1'b1; tick(); con_set_pih_h = 1'b0; con_pi_cycle_h = 1'b0;
    chk("hold_2_3", {pi_hold_h, pi_hold_lvl_h}, {7'h06, 3'd2});
    ebus_pi_e_h = '0; ticks(3);
    con_pi_dismiss_h = 1'b1; tick(); con_pi_dismiss_h = 1'b0;
    chk("dismiss1", {pi_hold_h, pi_hold_lvl_h}, {7'h04, 3'd3});
    con_pi_dismiss_h = 1'b1; tick(); con_pi_dismiss_h = 1'b0;
    chk("dismiss2", {pi_req_h, pi_hold_h, pi_hold_lvl_h}, {1'b0, 7'h00, 3'd0});
    con_pi_dismiss_h = 1'b1; tick(); con_pi_dismiss_h = 1'b0;
    chk("dismiss_empty", 32'(pi_hold_h), 32'h0);

    // Seq C: level 6 request pre-empted by level 1 before the cycle starts
    ebus_pi_e_h = 7'h20; ticks(3);
    chk("req_lvl6", {pi_req_h, pi_level_h}, {1'b1, 3'd6});
    ebus_pi_e_h = 7'h21; ticks(2);
    chk("still_lvl6", {pi_req_h, pi_level_h}, {1'b1, 3'd6});
    tick();
    chk("relatch_lvl1", {pi_req_h, pi_level_h}, {1'b1, 3'd1});
    con_pi_cycle_h = 1'b1; tick();
    con_set_pih_h = 1'b1; tick(); con_set_pih_h = 1'b0; con_pi_cycle_h = 1'b0;
    chk("hold_lvl1", {pi_hold_h, pi_hold_lvl_h}, {7'h01, 3'd1});
    ebus_pi_e_h = '0; ticks(3);
    con_pi_dismiss_h = 1'b1; tick(); con_pi_dismiss_h = 1'b0;

    // Seq D: program request raises and withdraws an interrupt
    cono(OP_SETP | 14'h10);
    chk("pir_set", {pi_pir_h, pi_req_h}, {7'h10, 1'b0});
    tick();
    chk("pir_req_lvl5", {pi_req_h, pi_level_h}, {1'b1, 3'd5});
    cono(OP_DROP | 14'h10);
    chk("pir_drop", {pi_pir_h, pi_req_h}, {7'h00, 1'b1});
    tick();
    chk("pir_withdrawn", {pi_req_h, pi_level_h, pi_hold_h}, {1'b0, 3'd0, 7'h00});

    // Seq E: dismiss and set_pih in the same cycle
    cono(OP_SETP | 14'h02); tick();
    con_pi_cycle_h = 1'b1; tick();
    con_set_pih_h = 1'b1; tick(); con_set_pih_h = 1'b0; con_pi_cycle_h = 1'b0;
    cono(OP_DROP | 14'h02);
    cono(OP_SETP | 14'h01); tick();
    chk("req_lvl1_over_hold2", {pi_req_h, pi_level_h, pi_hold_h}, {1'b1, 3'd1, 7'h02});
    con_pi_cycle_h = 1'b1; tick();
    con_set_pih_h = 1'b1; con_pi_dismiss_h = 1'b1; tick();
    con_set_pih_h = 1'b0; con_pi_dismiss_h = 1'b0; con_pi_cycle_h = 1'b0;
    chk("dismiss_and_set", {pi_hold_h, pi_hold_lvl_h}, {7'h01, 3'd1});
    cono(OP_CLR | OP_SETP | 14'h10);
    chk("clr_sys_wins", {pi_on_h, pi_act_h, pi_pir_h, pi_hold_h}, {1'b0, 7'h00, 7'h00, 7'h00});

    // Seq F: reset in the middle of a PI cycle
    cono(OP_SON | OP_LVON | 14'h7F);
    ebus_pi_e_h = 7'h08; ticks(3);
    con_pi_cycle_h = 1'b1; tick();
    chk("cycle_lvl4", {pi_req_h, pi_level_h}, {1'b0, 3'd4});
    mr_reset_h = 1'b1; con_set_pih_h = 1'b1; tick();
    chk("reset_in_cycle", dut_outs(), 32'h0);
    mr_reset_h = 1'b0; con_set_pih_h = 1'b0; con_pi_cycle_h = 1'b0; ebus_pi_e_h = '0;

`ifdef PI_DIAG_READ_EN
    cono(OP_SON | OP_LVON | 14'h7F);
    cono(OP_SETP | 14'h05);
    diag_read_pi_h = 1'b1; tick(); diag_read_pi_h = 1'b0;
    chk("diag_read", 32'(pi_diag_d_h), 32'({1'b1, 7'h7F, 7'h05, 7'h00}));
    tick();
    chk("diag_idle", 32'(pi_diag_d_h), 32'h0);
    mr_reset_h = 1'b1; tick(); mr_reset_h = 1'b0;
`endif

    // Randomized run against the reference model
    mr_reset_h = 1'b1; tick(); model_step(); mr_reset_h = 1'b0;
    cono_pi_h = 1'b1; cono_data_h = OP_SON | OP_LVON | 14'h7F;
    tick(); model_step();
    chk("rand_start", dut_outs(), model_outs());
    for (int it = 0; it < 2000; it++) begin
      mr_reset_h = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) ebus_pi_e_h = N'($urandom & $urandom);
      cono_pi_h   = ($urandom_range(0, 9) == 0);
      cono_data_h = 14'($urandom);
      if ($urandom_range(0, 7) != 0) cono_data_h[7] = 1'b0;
      con_pi_disable_h = ($urandom_range(0, 9) == 0);
      if (con_pi_cycle_h) con_pi_cycle_h = ($urandom_range(0, 2) != 0);
      else con_pi_cycle_h = (m_ph == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 19) == 0);
      con_set_pih_h    = con_pi_cycle_h ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      con_pi_dismiss_h = ($urandom_range(0, 9) == 0);
      tick();
      model_step();
      chk($sformatf("rand%0d", it), dut_outs(), model_outs());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pi_ctl_gen.md
Name: pi_ctl_gen

Overview:
- Parametrised priority-interrupt controller; next-generation successor to the fixed 7-level PI board logic.
- Collects per-level device requests and program requests, and applies the system-on and per-level-active masks.
- Arbitrates against in-progress (hold) levels and runs the PI-cycle handshake with the CON/EBOX.
- Sits between the EBUS PI lines and the CON PI-cycle microcode interface.

Parameters:
- NLEVELS, 7, number of priority levels; level 1 is highest priority, level NLEVELS is lowest; legal range 1..15.
- SYNC_STAGES, 2, synchroniser depth on device request lines; 0 means pass-through, unregistered.
- LW, $clog2(NLEVELS+1), width of encoded level numbers (derived, not overridden).

Ports:
- clk_pi_h  in  1  PI clock; everything is synchronous to its rising edge.
- mr_reset_h  in  1  master reset; synchronous, active-high.
- ebus_pi_e_h  in  NLEVELS  device request per level; bit i-1 is level i; asynchronous.
- cono_pi_h  in  1  one-cycle CONO PI strobe.
- cono_data_h  in  NLEVELS+7  CONO data:
  - bits [NLEVELS-1:0] are the level select mask.
  - Op bits above the mask, in order: clr_sys, drop_pir, set_pir, lvl_on, lvl_off, sys_off, sys_on.
- con_pi_disable_h  in  1  inhibits new interrupt requests.
- con_pi_cycle_h  in  1  EBOX is running a PI cycle; level for the request.
- con_set_pih_h  in  1  one-cycle pulse; commit hold for the granted level.
- con_pi_dismiss_h  in  1  one-cycle pulse; dismiss the highest-priority hold.
- pi_req_h  out  1  interrupt request to the EBOX.
- pi_level_h  out  LW  level being requested or serviced; 0 when idle.
- pi_hold_h  out  NLEVELS  hold (in-progress) flags.
- pi_hold_lvl_h  out  LW  number of the highest-priority held level; 0 if none.
- pi_act_h  out  NLEVELS  per-level active (enable) flags.
- pi_pir_h  out  NLEVELS  program request flags.
- pi_on_h  out  1  PI system on.

Behaviour:
- Reset:
  - All registers clear: pi_on, act, pir, hold, synchroniser stages and the latched level.
  - FSM goes to IDLE; every output is 0.
  - Reset wins over any concurrent input, including mid-cycle.
- Synchroniser: each ebus_pi_e_h bit passes through SYNC_STAGES flops to give dreq.
- Pending: pend[i] = pi_on & act[i] & (dreq[i] | pir[i]).
- Eligible: elig = pending levels whose number is strictly lower than pi_hold_lvl_h. When no hold is set, every pending level is eligible.
- Candidate: cand = lowest-numbered eligible level; 0 if none.
- FSM, registered:
  - IDLE: if cand != 0 and no disable, go to REQ and latch lvl = cand. pi_req_h rises the cycle after cand appears.
  - REQ:
    - pi_req_h = 1; pi_level_h = lvl.
    - Each cycle: if disable is asserted or cand == 0, go to IDLE (request withdrawn, no hold). Otherwise re-latch lvl = cand, so a higher-priority arrival pre-empts.
    - On con_pi_cycle_h: go to CYCLE with lvl frozen. Cycle start takes precedence over withdrawal in the same cycle.
  - CYCLE:
    - pi_req_h = 0; pi_level_h = lvl; disable and request changes are ignored.
    - con_set_pih_h: hold[lvl] <= 1, go to IDLE.
    - con_pi_cycle_h falling without set_pih: abort, go to IDLE, hold unchanged.
    - If both happen in the same cycle, set_pih is honoured.
- Dismiss: clears the lowest-numbered set hold bit; no-op when hold == 0.
  - Dismiss together with set_pih: the dismiss is computed on the pre-set hold vector, then the set is applied.
- CONO, applied on cono_pi_h with mask m:
  - clr_sys: clears pi_on, act, pir and hold; all other ops in the same word are ignored.
  - Otherwise ops apply in this order: drop_pir (pir &= ~m), set_pir (pir |= m), lvl_off (act &= ~m), lvl_on (act |= m), sys_off (pi_on = 0), sys_on (pi_on = 1).
  - The later op wins on conflict; for example, lvl_off and lvl_on together leave the masked levels on.
  - CONO effects are visible on outputs the next cycle. During CYCLE they affect only later arbitration.
- Program requests are never self-clearing; software must drop them.
- Mask bits for levels above NLEVELS do not exist.

Optional Feature:
- PI_DIAG_READ_EN:
  - Defined: adds input diag_read_pi_h (1 bit) and output pi_diag_d_h (3*NLEVELS+1 bits), registered.
  - pi_diag_d_h = {pi_on, act, pir, hold} one cycle after diag_read_pi_h; it is 0 otherwise.
  - Undefined: neither port exists, no extra logic.

Test Plan:
- Reset then CONO sys_on + lvl_on mask 0x7F; pulse ebus_pi level 3 -> pi_req_h = 1 and pi_level_h = 3 at SYNC_STAGES+1 cycles; con_pi_cycle_h, then set_pih -> hold = 0x04, pi_hold_lvl_h = 3, FSM IDLE.
- With hold[3] set, raise level 5 -> no request; raise level 2 -> request level 2; dismiss twice -> hold clears 2 then 3.
- In REQ at level 6, assert level 1 before con_pi_cycle_h -> pi_level_h becomes 1; the cycle services level 1.
- CONO set_pir mask 0x10 -> request level 5 with no device line; drop_pir -> request withdrawn next cycle with no hold.
- Same-cycle dismiss + set_pih with hold = 0x02 and lvl = 1 -> hold = 0x01. CONO clr_sys with set_pir -> pir = 0.
- Reset asserted in CYCLE -> all outputs 0 next cycle. PI_DIAG_READ_EN build: read returns the packed state.
